// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus: redirect requests in, fetch address and status out.
// The core (or bench) uses the master side; pc_fetch_unit uses the slave side.
interface pc_fetch_unit_if;
  // Redirect and control requests toward the fetch unit
  logic        stall;
  logic        jump_en;
  logic [31:0] jump_target;
  logic        branch_en;
  logic [31:0] branch_offset;
  logic        jr_en;
  logic [31:0] jr_target;
  logic        trap_clear;

  // Fetch address and status from the fetch unit
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [3:0]  pc_hi;
  logic        fetch_valid;
  logic        trap;
  logic [31:0] trap_addr;

  modport master (
    output stall, jump_en, jump_target, branch_en, branch_offset,
           jr_en, jr_target, trap_clear,
    input  pc, pc_plus4, pc_hi, fetch_valid, trap, trap_addr
  );

  modport slave (
    input  stall, jump_en, jump_target, branch_en, branch_offset,
           jr_en, jr_target, trap_clear,
    output pc, pc_plus4, pc_hi, fetch_valid, trap, trap_addr
  );
endinterface

// File: rtl/pc_fetch_unit.sv
// Program counter and next-PC selection.
// After reset the unit sits in BOOT for BOOT_CYCLES cycles, then fetches in RUN.
// Redirects are prioritised jr > jump > branch > sequential. A misaligned
// redirect target parks the unit in TRAP until trap_clear vectors it to
// TRAP_VECTOR. fetch_valid and trap are registered from the next state so
// they never glitch; pc_plus4/pc_hi are a plain adder off the pc register.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR  = 32'h0000_0180,
  parameter int unsigned BOOT_CYCLES  = 4
) (
  input  logic          clk,
  input  logic          rst,
  pc_fetch_unit_if.slave bus
);

  localparam int unsigned CNT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] BOOT_LOAD = CNT_W'(BOOT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRAP = 2'd2
  } state_t;

  // Word alignment check applied to every redirect target.
  function automatic logic is_misaligned(input logic [31:0] addr);
    return (addr[1:0] != 2'b00);
  endfunction

  state_t           state_r;
  state_t           state_s;
  logic [31:0]      pc_r;
  logic [31:0]      pc_s;
  logic [CNT_W-1:0] boot_cnt_r;
  logic [CNT_W-1:0] boot_cnt_s;
  logic [31:0]      trap_addr_r;
  logic [31:0]      trap_addr_s;
  logic             fetch_valid_r;
  logic             trap_r;

  logic [31:0]      pc_plus4_s;
  logic [31:0]      offset_shift_s;
  logic [31:0]      branch_target_s;
  logic [31:0]      target_s;
  logic             redirect_s;

  // Sequential and branch addresses; all sums wrap modulo 2^32.
  always_comb begin
    pc_plus4_s      = pc_r + 32'd4;
    offset_shift_s  = bus.branch_offset << 2;
    branch_target_s = pc_plus4_s + offset_shift_s;
  end

  // Prioritised next-address select: jr > jump > branch > sequential.
  always_comb begin
    target_s   = pc_plus4_s;
    redirect_s = 1'b0;
    if (bus.jr_en) begin
      target_s   = bus.jr_target;
      redirect_s = 1'b1;
    end else if (bus.jump_en) begin
      target_s   = bus.jump_target;
      redirect_s = 1'b1;
    end else if (bus.branch_en) begin
      target_s   = branch_target_s;
      redirect_s = 1'b1;
    end else begin
      target_s   = pc_plus4_s;
      redirect_s = 1'b0;
    end
  end

  // Next-state, next-pc, boot counter and trap-address capture.
  always_comb begin
    state_s     = state_r;
    pc_s        = pc_r;
    boot_cnt_s  = boot_cnt_r;
    trap_addr_s = trap_addr_r;
    case (state_r)
      ST_BOOT: begin
        // Inputs are ignored while booting; pc stays at the reset vector.
        if (boot_cnt_r == {CNT_W{1'b0}}) begin
          state_s = ST_RUN;
        end else begin
          boot_cnt_s = boot_cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
        end
      end
      ST_RUN: begin
        if (bus.stall) begin
          // Frozen; any redirect on the bus is dropped and re-presented later.
          pc_s = pc_r;
        end else if (redirect_s && is_misaligned(target_s)) begin
          trap_addr_s = target_s;
          state_s     = ST_TRAP;
        end else begin
          pc_s = target_s;
        end
      end
      ST_TRAP: begin
        if (bus.trap_clear) begin
          pc_s    = TRAP_VECTOR;
          state_s = ST_RUN;
        end else begin
          pc_s = pc_r;
        end
      end
      default: begin
        // Unreachable encoding: fall back to a clean boot.
        state_s     = ST_BOOT;
        pc_s        = RESET_VECTOR;
        boot_cnt_s  = BOOT_LOAD;
        trap_addr_s = 32'h0000_0000;
      end
    endcase
  end

  // State, pc and status registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r       <= ST_BOOT;
      pc_r          <= RESET_VECTOR;
      boot_cnt_r    <= BOOT_LOAD;
      trap_addr_r   <= 32'h0000_0000;
      fetch_valid_r <= 1'b0;
      trap_r        <= 1'b0;
    end else begin
      state_r       <= state_s;
      pc_r          <= pc_s;
      boot_cnt_r    <= boot_cnt_s;
      trap_addr_r   <= trap_addr_s;
      fetch_valid_r <= (state_s == ST_RUN);
      trap_r        <= (state_s == ST_TRAP);
    end
  end

  assign bus.pc          = pc_r;
  assign bus.pc_plus4    = pc_plus4_s;
  assign bus.pc_hi       = pc_plus4_s[31:28];
  assign bus.fetch_valid = fetch_valid_r;
  assign bus.trap        = trap_r;
  assign bus.trap_addr   = trap_addr_r;

  pc_fetch_unit_chk u_chk (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc_r),
    .fetch_valid (fetch_valid_r),
    .trap        (trap_r)
  );

endmodule

// Invariants of the fetch unit: pc is always word aligned and the unit is
// never fetching and trapped at the same time.
module pc_fetch_unit_chk (
  input logic        clk,
  input logic        rst,
  input logic [31:0] pc,
  input logic        fetch_valid,
  input logic        trap
);

  a_pc_aligned: assert property (@(posedge clk) disable iff (rst) pc[1:0] == 2'b00);

  a_run_trap_excl: assert property (@(posedge clk) disable iff (rst) !(fetch_valid && trap));

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: boot timing, redirect priority, trap
// entry/exit, stall, wrap-around and asynchronous reset in TRAP and BOOT.
module tb_pc_fetch_unit;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  pc_fetch_unit_if bus ();

  pc_fetch_unit #(
    .RESET_VECTOR (32'h0000_0000),
    .TRAP_VECTOR  (32'h0000_0180),
    .BOOT_CYCLES  (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    bus.stall         = 1'b0;
    bus.jump_en       = 1'b0;
    bus.jump_target   = 32'h0000_0000;
    bus.branch_en     = 1'b0;
    bus.branch_offset = 32'h0000_0000;
    bus.jr_en         = 1'b0;
    bus.jr_target     = 32'h0000_0000;
    bus.trap_clear    = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    clr_inputs();
    step();
    step();

    // 1. Reset state and boot delay
    chk("rst_pc",        bus.pc, 32'h0000_0000);
    chk("rst_pc_plus4",  bus.pc_plus4, 32'h0000_0004);
    chk("rst_fv",        {31'd0, bus.fetch_valid}, 32'd0);
    chk("rst_trap",      {31'd0, bus.trap}, 32'd0);
    chk("rst_trap_addr", bus.trap_addr, 32'h0000_0000);
    rst = 1'b0;
    bus.jump_en     = 1'b1;              // must be ignored during BOOT
    bus.jump_target = 32'h0000_0040;
    chk("boot_fv0", {31'd0, bus.fetch_valid}, 32'd0);
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("boot_fv%0d", i), {31'd0, bus.fetch_valid}, 32'd0);
    end
    step();
    chk("boot_done_fv", {31'd0, bus.fetch_valid}, 32'd1);
    chk("boot_done_pc", bus.pc, 32'h0000_0000);
    clr_inputs();
    step();
    chk("seq_pc4", bus.pc, 32'h0000_0004);
    step();
    chk("seq_pc8", bus.pc, 32'h0000_0008);
    chk("seq_plus4", bus.pc_plus4, 32'h0000_000C);

    // 2. Jump
    bus.jump_en     = 1'b1;
    bus.jump_target = 32'h0040_0010;
    step();
    chk("jmp_pc_a", bus.pc, 32'h0040_0010);
    chk("jmp_pc_hi", {28'd0, bus.pc_hi}, 32'h0000_0000);
    bus.jump_target = 32'h0040_0100;
    step();
    chk("jmp_pc_b", bus.pc, 32'h0040_0100);

    // 3. Branch and priority
    bus.jump_target = 32'h0000_0100;
    step();
    chk("jmp_0x100", bus.pc, 32'h0000_0100);
    bus.jump_en       = 1'b0;
    bus.branch_en     = 1'b1;
    bus.branch_offset = 32'hFFFF_FFFE;
    step();
    chk("br_back", bus.pc, 32'h0000_00FC);
    bus.jump_en     = 1'b1;
    bus.jump_target = 32'h0000_0100;
    step();
    chk("jmp_over_br", bus.pc, 32'h0000_0100);
    bus.jump_target = 32'h0000_0300;
    bus.jr_en       = 1'b1;
    bus.jr_target   = 32'h0000_0200;
    step();
    chk("jr_over_all", bus.pc, 32'h0000_0200);
    clr_inputs();
    bus.branch_en     = 1'b1;
    bus.branch_offset = 32'h0000_0004;
    step();
    chk("br_fwd", bus.pc, 32'h0000_0214);
    clr_inputs();

    // 4. Misaligned jr -> TRAP, then clear
    bus.jr_en     = 1'b1;
    bus.jr_target = 32'h0000_0203;
    step();
    chk("trap_on",      {31'd0, bus.trap}, 32'd1);
    chk("trap_fv",      {31'd0, bus.fetch_valid}, 32'd0);
    chk("trap_pc_hold", bus.pc, 32'h0000_0214);
    chk("trap_addr_jr", bus.trap_addr, 32'h0000_0203);
    bus.jump_en     = 1'b1;
    bus.jump_target = 32'h0000_0400;
    step();
    chk("trap_ignore_pc", bus.pc, 32'h0000_0214);
    chk("trap_stay",      {31'd0, bus.trap}, 32'd1);
    clr_inputs();
    bus.trap_clear = 1'b1;
    step();
    chk("trap_clr_pc",   bus.pc, 32'h0000_0180);
    chk("trap_clr_fv",   {31'd0, bus.fetch_valid}, 32'd1);
    chk("trap_clr_trap", {31'd0, bus.trap}, 32'd0);
    chk("trap_addr_kept", bus.trap_addr, 32'h0000_0203);
    clr_inputs();
    bus.jump_en     = 1'b1;
    bus.jump_target = 32'h0000_0102;
    step();
    chk("jtrap_on",   {31'd0, bus.trap}, 32'd1);
    chk("jtrap_addr", bus.trap_addr, 32'h0000_0102);
    chk("jtrap_pc",   bus.pc, 32'h0000_0180);
    clr_inputs();
    bus.trap_clear = 1'b1;
    step();
    chk("jtrap_clr_pc", bus.pc, 32'h0000_0180);
    clr_inputs();

    // 5. Stall holds pc; held jump taken when stall falls
    bus.stall       = 1'b1;
    bus.jump_en     = 1'b1;
    bus.jump_target = 32'h0000_0500;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("stall_pc%0d", i), bus.pc, 32'h0000_0180);
    end
    bus.stall = 1'b0;
    step();
    chk("stall_release", bus.pc, 32'h0000_0500);
    bus.jump_en = 1'b0;
    step();
    chk("post_stall_seq", bus.pc, 32'h0000_0504);

    // Wrap-around and pc_hi
    bus.jump_en     = 1'b1;
    bus.jump_target = 32'hFFFF_FFFC;
    step();
    chk("wrap_pc",     bus.pc, 32'hFFFF_FFFC);
    chk("wrap_plus4",  bus.pc_plus4, 32'h0000_0000);
    chk("wrap_pc_hi",  {28'd0, bus.pc_hi}, 32'h0000_0000);
    bus.jump_en = 1'b0;
    step();
    chk("wrap_to_zero", bus.pc, 32'h0000_0000);
    bus.jump_en     = 1'b1;
    bus.jump_target = 32'hEFFF_FFFC;
    step();
    chk("pc_hi_f", {28'd0, bus.pc_hi}, 32'h0000_000F);
    bus.jump_en = 1'b0;
    step();
    chk("seg_cross", bus.pc, 32'hF000_0000);

    // 6. Reset mid-TRAP
    bus.jr_en     = 1'b1;
    bus.jr_target = 32'h0000_0001;
    step();
    chk("trap2_on", {31'd0, bus.trap}, 32'd1);
    clr_inputs();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_trap_pc",   bus.pc, 32'h0000_0000);
    chk("rst_trap_trap", {31'd0, bus.trap}, 32'd0);
    chk("rst_trap_fv",   {31'd0, bus.fetch_valid}, 32'd0);
    chk("rst_trap_addr0", bus.trap_addr, 32'h0000_0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.trap_clear = 1'b1;               // ignored during BOOT
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("reboot_fv%0d", i), {31'd0, bus.fetch_valid}, 32'd0);
    end
    step();
    chk("reboot_run", {31'd0, bus.fetch_valid}, 32'd1);
    chk("reboot_pc",  bus.pc, 32'h0000_0000);
    clr_inputs();

    // Reset mid-BOOT restarts the full count
    #2;
    rst = 1'b1;
    #1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    step();
    #2;
    rst = 1'b1;
    #1;
    chk("rst_boot_pc", bus.pc, 32'h0000_0000);
    chk("rst_boot_fv", {31'd0, bus.fetch_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk($sformatf("reboot2_fv%0d", i), {31'd0, bus.fetch_valid}, 32'd0);
    end
    step();
    chk("reboot2_run", {31'd0, bus.fetch_valid}, 32'd1);
    step();
    chk("reboot2_seq", bus.pc, 32'h0000_0004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
